// File: rtl/rv32i_multicycle_controller_pkg.sv
// Shared types for the multicycle RV32I controller: opcodes, ALU operations,
// FSM states and the datapath mux-select encodings.
package rv32i_multicycle_controller_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_control_t;

    // Operation class a state asks the ALU decoder for.
    typedef enum logic [1:0] {
        ALU_CLASS_ADD, ALU_CLASS_SUB, ALU_CLASS_FUNCT, ALU_CLASS_BRANCH
    } alu_class_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
        S_LINK, S_ILLEGAL, S_HALT
    } mc_state_t;

    typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLD_PC, SRC_A_REG, SRC_A_ZERO} alu_src_a_t;
    typedef enum logic [1:0] {SRC_B_REG, SRC_B_IMM, SRC_B_FOUR} alu_src_b_t;
    typedef enum logic [1:0] {RES_ALU_OUT, RES_DATA, RES_ALU_RESULT} result_src_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;

    // Loads accept LB/LH/LW/LBU/LHU, stores accept SB/SH/SW.
    function automatic logic mem_funct3_ok(input logic is_store, input logic [2:0] f3);
        if (is_store) return f3 inside {3'd0, 3'd1, 3'd2};
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

endpackage

// File: rtl/rv32i_multicycle_controller_alu_decoder.sv
// ALU decoder: maps the operation class requested by the FSM plus funct3,
// funct7b5 and op[5] to an ALU operation, flagging unsupported branch funct3.
module rv32i_alu_decoder
    import rv32i_multicycle_controller_pkg::*;
(
    input  alu_class_t   alu_class,
    input  logic [2:0]   funct3,
    input  logic         funct7b5,
    input  logic         op5,
    output alu_control_t alu_control,
    output logic         funct_illegal
);

    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (alu_class)
            ALU_CLASS_ADD: alu_control = ALU_ADD;
            ALU_CLASS_SUB: alu_control = ALU_SUB;
            ALU_CLASS_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        // Bit 30 is immediate data for ADDI, so SUB needs op[5].
                        if (op5 && funct7b5) alu_control = ALU_SUB;
                        else                 alu_control = ALU_ADD;
                    end
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: begin
                        if (funct7b5) alu_control = ALU_SRA;
                        else          alu_control = ALU_SRL;
                    end
                    3'b110: alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: begin
                case (funct3)
                    3'b000, 3'b001: alu_control = ALU_SUB;
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        funct_illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Multicycle RV32I control unit: instruction-sequencing FSM driving datapath
// selects and write enables, with memory wait states and an instret counter.
module rv32i_multicycle_controller
    import rv32i_multicycle_controller_pkg::*;
#(
    parameter int INSTRET_WIDTH   = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     zero,
    input  logic                     alu_lsb,
    input  logic                     mem_ready,
    output logic                     pc_write,
    output logic                     ir_write,
    output logic                     reg_write,
    output logic                     mem_write,
    output logic                     adr_src,
    output logic [1:0]               alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               result_src,
    output logic [2:0]               imm_src,
    output alu_control_t             alu_control,
    output logic                     illegal,
    output logic [INSTRET_WIDTH-1:0] instret
);

    mc_state_t                state, state_next;
    logic                     illegal_q;
    logic [INSTRET_WIDTH-1:0] instret_q;

    alu_src_a_t  src_a;
    alu_src_b_t  src_b;
    result_src_t res_src;
    imm_src_t    imm_sel;
    alu_class_t  alu_class;
    logic        funct_illegal;
    logic        branch_taken;
    logic        pc_we, ir_we, reg_we, mem_we;

    rv32i_alu_decoder u_alu_decoder (
        .alu_class     (alu_class),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .op5           (op[5]),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    // BGE/BNE/BGEU are the complements of BLT/BEQ/BLTU, selected by funct3[0].
    assign branch_taken = (funct3[2] ? alu_lsb : zero) ^ funct3[0];

    // Datapath selects depend only on the state and the latched opcode.
    always_comb begin
        src_a     = SRC_A_PC;
        src_b     = SRC_B_REG;
        res_src   = RES_ALU_OUT;
        imm_sel   = IMM_I;
        alu_class = ALU_CLASS_ADD;
        adr_src   = 1'b0;
        case (state)
            S_FETCH: begin
                src_b   = SRC_B_FOUR;
                res_src = RES_ALU_RESULT;
            end
            S_DECODE: begin
                src_a = SRC_A_OLD_PC;
                src_b = SRC_B_IMM;
                if (op == OP_JAL) imm_sel = IMM_J;
                else              imm_sel = IMM_B;
            end
            S_MEM_ADR: begin
                src_a = SRC_A_REG;
                src_b = SRC_B_IMM;
                if (op == OP_STORE) imm_sel = IMM_S;
            end
            S_MEM_READ, S_MEM_WRITE: adr_src = 1'b1;
            S_MEM_WB: res_src = RES_DATA;
            S_EXEC_R: begin
                src_a     = SRC_A_REG;
                alu_class = ALU_CLASS_FUNCT;
            end
            S_EXEC_I: begin
                src_a     = SRC_A_REG;
                src_b     = SRC_B_IMM;
                alu_class = ALU_CLASS_FUNCT;
            end
            S_EXEC_U: begin
                if (op == OP_LUI) src_a = SRC_A_ZERO;
                else              src_a = SRC_A_OLD_PC;
                src_b   = SRC_B_IMM;
                imm_sel = IMM_U;
            end
            S_BRANCH: begin
                src_a     = SRC_A_REG;
                alu_class = ALU_CLASS_BRANCH;
            end
            S_JAL, S_LINK: begin
                src_a = SRC_A_OLD_PC;
                src_b = SRC_B_FOUR;
            end
            S_JALR: begin
                src_a   = SRC_A_REG;
                src_b   = SRC_B_IMM;
                res_src = RES_ALU_RESULT;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    pc_we      = 1'b1;
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_IMM:            state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI, OP_AUIPC:  state_next = S_EXEC_U;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR: begin
                if (!mem_funct3_ok(op == OP_STORE, funct3)) state_next = S_ILLEGAL;
                else if (op == OP_STORE)                   state_next = S_MEM_WRITE;
                else                                       state_next = S_MEM_READ;
            end
            S_MEM_READ: if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB: begin
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_we = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                if (funct_illegal) state_next = S_ILLEGAL;
                else               state_next = S_ALU_WB;
            end
            S_EXEC_U: state_next = S_ALU_WB;
            S_ALU_WB: begin
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                if (funct_illegal) begin
                    state_next = S_ILLEGAL;
                end else begin
                    pc_we      = branch_taken;
                    state_next = S_FETCH;
                end
            end
            S_JAL: begin
                pc_we      = 1'b1;
                state_next = S_ALU_WB;
            end
            S_JALR: begin
                pc_we      = 1'b1;
                state_next = S_LINK;
            end
            S_LINK: state_next = S_ALU_WB;
            S_ILLEGAL: begin
                if (HALT_ON_ILLEGAL) state_next = S_HALT;
                else                 state_next = S_FETCH;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else if (ena) begin
            state <= state_next;
            if (state == S_ILLEGAL) illegal_q <= 1'b1;
            // Skipped illegal instructions and fetch stalls do not retire.
            if (state_next == S_FETCH && state != S_FETCH && state != S_ILLEGAL)
                instret_q <= instret_q + INSTRET_WIDTH'(1);
        end
    end

    assign pc_write   = pc_we  & ena;
    assign ir_write   = ir_we  & ena;
    assign reg_write  = reg_we & ena;
    assign mem_write  = mem_we & ena;
    assign alu_src_a  = src_a;
    assign alu_src_b  = src_b;
    assign result_src = res_src;
    assign imm_src    = imm_sel;
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule

// File: doc/rv32i_multicycle_controller.md
# rv32i_multicycle_controller

Main control unit for the multicycle RV32I core: an instruction-sequencing FSM with ALU and immediate decode. It drives every datapath mux select and write enable, stalls on a variable-latency memory handshake, honours the core `ena`, and flags illegal instructions. Compared with a fixed single-latency sequencer, it adds:
- `mem_ready` wait states;
- all six branch conditions;
- JAL, JALR, LUI and AUIPC;
- a parametrised retired-instruction counter.

## Interface
Parameters:
- `INSTRET_WIDTH`, default 32: width of the retired-instruction counter.
- `HALT_ON_ILLEGAL`, default 1: 1 means an illegal instruction enters HALT; 0 means skip it and continue.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  core enable; low freezes the FSM and forces all write enables to 0.
- `op`  in  7  opcode, `instr[6:0]`.
- `funct3`  in  3  `instr[14:12]`.
- `funct7b5`  in  1  `instr[30]`.
- `zero`  in  1  ALU result is zero.
- `alu_lsb`  in  1  ALU `result[0]`, used for SLT/SLTU branch compares.
- `mem_ready`  in  1  memory has completed the current access.
- `pc_write`  out  1  load PC from `result`.
- `ir_write`  out  1  load the IR and the old-PC register. The old-PC register is loaded only by `ir_write`.
- `reg_write`  out  1  register-file write enable.
- `mem_write`  out  1  memory write enable.
- `adr_src`  out  1  0 = PC, 1 = `result`.
- `alu_src_a`  out  2  0 = PC, 1 = OLD_PC, 2 = REG_A, 3 = ZERO.
- `alu_src_b`  out  2  0 = REG_B, 1 = IMM, 2 = FOUR.
- `result_src`  out  2  0 = ALU_OUT, 1 = DATA, 2 = ALU_RESULT.
- `imm_src`  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- `alu_control`  out  `alu_control_t`  ALU operation.
- `illegal`  out  1  sticky illegal-instruction flag.
- `instret`  out  `INSTRET_WIDTH`  count of retired instructions.

## Operation
States and actions. ALU operation is ADD unless stated. `pc_write` and the `ir_write` pulse are both gated by `mem_ready`.
- **FETCH**: `adr_src`=0; PC+4 → `result_src`=ALU_RESULT. When `mem_ready`: assert `ir_write` and `pc_write`, go to DECODE.
- **DECODE**: OLD_PC + IMM. `imm_src` is J when `op`=JAL, otherwise B. Result is latched in ALU_OUT. Dispatch on `op`:
  - load or store → MEM_ADR
  - OP → EXEC_R
  - OP-IMM → EXEC_I
  - BRANCH → BRANCH
  - JAL → JAL
  - JALR → JALR
  - LUI or AUIPC → EXEC_U
  - any other opcode → ILLEGAL
- **MEM_ADR**: REG_A + IMM. `imm_src` is S for stores, I for loads. Go to MEM_READ (load) or MEM_WRITE (store).
- **MEM_READ**: `adr_src`=1, `result_src`=ALU_OUT. Wait for `mem_ready`, then go to MEM_WB.
- **MEM_WB**: `result_src`=DATA, `reg_write`, go to FETCH.
- **MEM_WRITE**: `adr_src`=1, `result_src`=ALU_OUT. `mem_write` stays high until `mem_ready`, then go to FETCH.
- **EXEC_R / EXEC_I**: REG_A op REG_B or IMM. `alu_control` comes from `funct3`/`funct7b5`. SUB applies only when `op[5]`=1 and `funct7b5`=1. Go to ALU_WB.
- **EXEC_U**: `alu_src_a` is ZERO for LUI, OLD_PC for AUIPC; plus IMM(U). Go to ALU_WB.
- **ALU_WB**: `result_src`=ALU_OUT, `reg_write`, go to FETCH.
- **BRANCH**: REG_A vs REG_B, `result_src`=ALU_OUT.
  - BEQ/BNE use SUB: taken when `zero` / `!zero`.
  - BLT/BGE use SLT; BLTU/BGEU use SLTU: taken when `alu_lsb` / `!alu_lsb`.
  - `pc_write` = taken. Go to FETCH.
- **JAL**: `result_src`=ALU_OUT, `pc_write`; compute OLD_PC + 4. Go to ALU_WB.
- **JALR**: REG_A + IMM(I), `result_src`=ALU_RESULT, `pc_write`. Go to LINK.
- **LINK**: OLD_PC + 4. Go to ALU_WB.
- **ILLEGAL**: set `illegal`. Next state is HALT if `HALT_ON_ILLEGAL`, otherwise FETCH.
  - Also entered on an unsupported `funct3` in OP/OP-IMM/BRANCH (decided in the EXEC/BRANCH state, no writes that cycle) and on an unsupported `funct3` in load/store.
- **HALT**: all enables 0. Left only by reset.

Rules:
- `instret` increments on the transition into FETCH from any state except reset and ILLEGAL. It wraps modulo 2^`INSTRET_WIDTH`.
- `ena`=0: state, `illegal` and `instret` hold, and every write enable is 0 that cycle. Mux selects still follow the state.
- Reset mid-instruction: the FSM returns to FETCH immediately. No partial register write occurs after `rst` falls.

## Timing
- Reset values: state=FETCH, `illegal`=0, `instret`=0.
- Write enables are Moore outputs of the state, except these, which are combinational on inputs:
  - `pc_write`/`ir_write` in FETCH (on `mem_ready`);
  - `pc_write` in BRANCH (on `zero`/`alu_lsb`);
  - all enables when gated by `ena`.
- CPI with zero-wait memory: load 5, store 4, R/I/U 4, branch 3, JAL 4, JALR 5. Each memory stall cycle adds 1.

## Structure
- The state enum `mc_state_t` and the select enums go in `rv32i_defines.sv`: `alu_src_a_t`, `alu_src_b_t`, `result_src_t`, `imm_src_t`.
- Opcode constants and `alu_control_t` are reused from the existing shared files.
- Sub-module `rv32i_alu_decoder`: combinational mapping of state-requested class (ADD, SUB, FUNCT, BRANCH) plus `funct3`/`funct7b5`/`op[5]` → `alu_control` and a `funct_illegal` output.

## Test plan
- **Reset and fetch**: `rst` low then high; `mem_ready` held 0 for 3 cycles → no `ir_write`/`pc_write` while waiting, then both pulse in the 4th cycle.
- **ADD x3,x1,x2** with zero-wait memory → state sequence FETCH, DECODE, EXEC_R, ALU_WB; `alu_control`=ADD; `reg_write` in cycle 4; `instret` 0→1.
- **BLTU** with `alu_lsb`=1 → `pc_write`=1 in BRANCH; with `alu_lsb`=0 → `pc_write`=0. Both paths take 3 cycles.
- **SW** with `mem_ready` delayed 2 cycles → `mem_write` high for 3 cycles with `adr_src`=1; `reg_write` never asserted.
- **Opcode 7'b1111111**:
  - `HALT_ON_ILLEGAL`=1 → `illegal`=1 and the FSM stays in HALT for 100 cycles with `instret` frozen.
  - `HALT_ON_ILLEGAL`=0 → returns to FETCH.
- **`ena` and reset interaction**: `ena`=0 during MEM_WB → state holds and `reg_write`=0. Assert `rst` during MEM_READ → state=FETCH asynchronously.
